// File: rtl/if_id_stage_pkg.sv
// Shared definitions for the IF/ID pipeline register: MIPS field positions,
// occupancy state encoding and the fetch entry record.
package if_id_stage_pkg;

  localparam int OPCODE_MSB = 31;
  localparam int OPCODE_LSB = 26;
  localparam int RS_MSB     = 25;
  localparam int RS_LSB     = 21;
  localparam int RT_MSB     = 20;
  localparam int RT_LSB     = 16;
  localparam int RD_MSB     = 15;
  localparam int RD_LSB     = 11;
  localparam int SHAMT_MSB  = 10;
  localparam int SHAMT_LSB  = 6;
  localparam int FUNCT_MSB  = 5;
  localparam int FUNCT_LSB  = 0;
  localparam int IMM_MSB    = 15;
  localparam int IMM_LSB    = 0;
  localparam int TARGET_MSB = 25;
  localparam int TARGET_LSB = 0;

  localparam int PC_BITS    = 32;
  localparam int INSTR_BITS = 32;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } state_t;

  typedef struct packed {
    logic [PC_BITS-1:0]    pc;
    logic [INSTR_BITS-1:0] instr;
  } entry_t;

endpackage

// File: rtl/if_id_stage_split.sv
// Combinational MIPS field splitter; slices a 32-bit-or-wider instruction word
// into the R/I/J-format fields used by decode.
module mips_field_split
  import if_id_stage_pkg::*;
#(
  parameter int instr_bits = 32
) (
  input  logic [instr_bits-1:0] instr,
  output logic [5:0]            opcode,
  output logic [4:0]            rs,
  output logic [4:0]            rt,
  output logic [4:0]            rd,
  output logic [4:0]            shamt,
  output logic [5:0]            funct,
  output logic [15:0]           imm,
  output logic [25:0]           target
);

  assign opcode = instr[OPCODE_MSB:OPCODE_LSB];
  assign rs     = instr[RS_MSB:RS_LSB];
  assign rt     = instr[RT_MSB:RT_LSB];
  assign rd     = instr[RD_MSB:RD_LSB];
  assign shamt  = instr[SHAMT_MSB:SHAMT_LSB];
  assign funct  = instr[FUNCT_MSB:FUNCT_LSB];
  assign imm    = instr[IMM_MSB:IMM_LSB];
  assign target = instr[TARGET_MSB:TARGET_LSB];

endmodule

// File: rtl/if_id_stage.sv
// IF/ID pipeline register with a two-entry skid buffer and flush.
// Optional performance counters are enabled by defining IF_ID_PERF_CNT_EN.
module if_id_stage
  import if_id_stage_pkg::*;
#(
  parameter int instr_bits = 32,
  parameter int pc_bits    = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [instr_bits-1:0] in_instr,
  input  logic [pc_bits-1:0]    in_pc,
  input  logic                  flush,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [pc_bits-1:0]    out_pc,
  output logic [5:0]            out_opcode,
  output logic [4:0]            out_rs,
  output logic [4:0]            out_rt,
  output logic [4:0]            out_rd,
  output logic [4:0]            out_shamt,
  output logic [5:0]            out_funct,
  output logic [25:0]           out_target,
  output logic [15:0]           out_imm
`ifdef IF_ID_PERF_CNT_EN
  ,
  output logic [15:0]           stall_cnt,
  output logic [15:0]           flush_cnt
`endif
);

  typedef struct packed {
    logic [pc_bits-1:0]    pc;
    logic [instr_bits-1:0] instr;
  } slot_t;

  state_t state;
  slot_t  main_q;
  slot_t  skid_q;
  slot_t  incoming;
  logic   in_ready_q;
  logic   out_valid_q;
  logic   accept;
  logic   drain;

  assign incoming = '{pc: in_pc, instr: in_instr};
  assign accept   = in_valid && in_ready_q;
  assign drain    = out_valid_q && out_ready;

  // NOTE: in_ready and out_valid are flops updated with the state, so out_ready
  // never reaches in_ready combinationally; the skid entry absorbs that lag.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= EMPTY;
      main_q      <= '0;
      skid_q      <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
    end else if (flush) begin
      state       <= EMPTY;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
    end else begin
      unique case (state)
        EMPTY: begin
          if (accept) begin
            main_q      <= incoming;
            state       <= ONE;
            out_valid_q <= 1'b1;
          end
        end
        ONE: begin
          if (accept && drain) begin
            main_q <= incoming;
          end else if (accept) begin
            skid_q     <= incoming;
            state      <= FULL;
            in_ready_q <= 1'b0;
          end else if (drain) begin
            state       <= EMPTY;
            out_valid_q <= 1'b0;
          end
        end
        FULL: begin
          if (drain) begin
            main_q     <= skid_q;
            state      <= ONE;
            in_ready_q <= 1'b1;
          end
        end
        default: begin
          state       <= EMPTY;
          in_ready_q  <= 1'b1;
          out_valid_q <= 1'b0;
        end
      endcase
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign out_pc    = main_q.pc;

  mips_field_split #(
    .instr_bits(instr_bits)
  ) u_split (
    .instr (main_q.instr),
    .opcode(out_opcode),
    .rs    (out_rs),
    .rt    (out_rt),
    .rd    (out_rd),
    .shamt (out_shamt),
    .funct (out_funct),
    .imm   (out_imm),
    .target(out_target)
  );

`ifdef IF_ID_PERF_CNT_EN
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      if (out_valid_q && !out_ready && stall_cnt != 16'hFFFF) stall_cnt <= stall_cnt + 16'd1;
      if (flush && flush_cnt != 16'hFFFF) flush_cnt <= flush_cnt + 16'd1;
    end
  end
`endif

endmodule
